// File: rtl/muldiv_sequencer_pkg.sv
// Shared types and constants for the RV32M iterative multiply/divide unit.
// Imported by the EX-stage sequencer and its datapath.
package muldiv_sequencer_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1;

   localparam logic [6:0] OPCODE_OP     = 7'b0110011;
   localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

   // Encoding equals funct3 of the M-extension instructions.
   typedef enum logic [2:0] {
      MD_MUL    = 3'd0,
      MD_MULH   = 3'd1,
      MD_MULHSU = 3'd2,
      MD_MULHU  = 3'd3,
      MD_DIV    = 3'd4,
      MD_DIVU   = 3'd5,
      MD_REM    = 3'd6,
      MD_REMU   = 3'd7
   } muldiv_op_e;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_CALC = 2'd1,
      MD_DONE = 2'd2
   } md_state_e;

   function automatic logic is_div_op(muldiv_op_e op);
      return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
   endfunction

endpackage

// File: rtl/muldiv_sequencer_datapath.sv
// Bit-serial multiply/divide datapath: shift-add multiplier and restoring divider
// sharing one accumulator, with sign correction applied to the final result.
module muldiv_datapath
   import muldiv_sequencer_pkg::*;
#(
   parameter int W = DATA_WIDTH
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         iterate,
   input  muldiv_op_e   op,
   input  logic [W-1:0] operand1,
   input  logic [W-1:0] operand2,
   output logic [W-1:0] result
);

   logic [2*W-1:0] acc_q;
   logic [W-1:0]   opb_q;
   logic [W-1:0]   rem_q;
   muldiv_op_e     op_q;
   logic           neg_q;

   logic           sa, sb, neg_d;
   logic [W-1:0]   mag_a, mag_b;
   logic [W:0]     mul_sum;
   logic [W:0]     div_shifted, div_trial;
   logic           qbit;
   logic [2*W-1:0] prod;
   logic [W-1:0]   quo, remv;

   always_comb begin
      sa    = (op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM}) & operand1[W-1];
      sb    = (op inside {MD_MULH, MD_DIV, MD_REM}) & operand2[W-1];
      mag_a = sa ? -operand1 : operand1;
      mag_b = sb ? -operand2 : operand2;
      case (op)
         MD_MULH, MD_DIV: neg_d = sa ^ sb;
         MD_MULHSU, MD_REM: neg_d = sa;
         default: neg_d = 1'b0;
      endcase
   end

   // Multiply: add multiplicand into the upper half when the LSB is set, then shift right.
   // Divide: the dividend shifts out of acc[W-1] into the partial remainder.
   always_comb begin
      mul_sum     = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? opb_q : {W{1'b0}})};
      div_shifted = {rem_q, acc_q[W-1]};
      div_trial   = div_shifted - {1'b0, opb_q};
      qbit        = ~div_trial[W];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         opb_q <= '0;
         rem_q <= '0;
         op_q  <= MD_MUL;
         neg_q <= 1'b0;
      end else if (load) begin
         acc_q <= {{W{1'b0}}, mag_a};
         opb_q <= mag_b;
         rem_q <= '0;
         op_q  <= op;
         neg_q <= neg_d;
      end else if (iterate) begin
         if (is_div_op(op_q)) begin
            rem_q <= qbit ? div_trial[W-1:0] : div_shifted[W-1:0];
            acc_q <= {acc_q[2*W-1:W], acc_q[W-2:0], qbit};
         end else begin
            acc_q <= {mul_sum, acc_q[W-1:1]};
         end
      end
   end

   always_comb begin
      prod = neg_q ? -acc_q : acc_q;
      quo  = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
      remv = neg_q ? -rem_q : rem_q;
      case (op_q)
         MD_MUL:                       result = prod[W-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU: result = prod[2*W-1:W];
         MD_DIV, MD_DIVU:              result = quo;
         default:                      result = remv;
      endcase
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// EX-stage sequencer for the iterative RV32M unit: accepts an M-op, stalls the
// front of the pipe while computing, and presents a one-cycle result pulse.
module muldiv_sequencer
   import muldiv_sequencer_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   input  logic                  flush_i,
   input  muldiv_op_e            op_i,
   input  logic [DATA_WIDTH-1:0] operand1_i,
   input  logic [DATA_WIDTH-1:0] operand2_i,
   output logic                  stall_o,
   output logic                  busy_o,
   output logic                  result_valid_o,
   output logic [DATA_WIDTH-1:0] result_o,
   output md_state_e             dbg_state_o
);

   // Handshake: start_i is sampled only in IDLE; a request is taken when
   // start_i=1 and flush_i=0 in that cycle, and result_valid_o pulses for
   // exactly one cycle with result_o final. There is no back-pressure.

   localparam logic [DATA_WIDTH-1:0] INT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic [CNT_WIDTH-1:0]  CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

   md_state_e             state_q, state_d;
   logic [CNT_WIDTH-1:0]  cnt_q;
   logic                  fast_q;
   logic [DATA_WIDTH-1:0] fast_res_q;
   logic [DATA_WIDTH-1:0] result_q;

   logic                  accept, fast, div_zero, div_ovf, is_rem;
   logic                  dp_load, dp_iterate, done_ok;
   logic [DATA_WIDTH-1:0] fast_val, dp_result, final_res;

   assign accept = (state_q == MD_IDLE) & start_i & ~flush_i;

   // Divide-by-zero and signed overflow are resolved at accept, skipping CALC.
   always_comb begin
      is_rem   = op_i inside {MD_REM, MD_REMU};
      div_zero = (operand2_i == '0);
      div_ovf  = (op_i inside {MD_DIV, MD_REM}) & (operand1_i == INT_MIN) & (operand2_i == '1);
      fast     = is_div_op(op_i) & (div_zero | div_ovf);
      if (div_zero) fast_val = is_rem ? operand1_i : '1;
      else          fast_val = is_rem ? '0 : operand1_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= MD_IDLE;
         cnt_q      <= '0;
         fast_q     <= 1'b0;
         fast_res_q <= '0;
         result_q   <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            cnt_q      <= '0;
            fast_q     <= fast;
            fast_res_q <= fast_val;
         end else if (state_q == MD_CALC) begin
            cnt_q <= cnt_q + 1'b1;
         end
         if (done_ok) result_q <= final_res;
      end
   end

   always_comb begin
      state_d = state_q;
      if (flush_i) begin
         state_d = MD_IDLE;
      end else begin
         case (state_q)
            MD_IDLE: if (accept) state_d = fast ? MD_DONE : MD_CALC;
            MD_CALC: if (cnt_q == CNT_LAST) state_d = MD_DONE;
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
         endcase
      end
   end

   always_comb begin
      stall_o        = accept | ((state_q == MD_CALC) & ~flush_i);
      busy_o         = (state_q != MD_IDLE);
      done_ok        = (state_q == MD_DONE) & ~flush_i;
      result_valid_o = done_ok;
      dp_load        = accept;
      dp_iterate     = (state_q == MD_CALC) & ~flush_i;
      final_res      = fast_q ? fast_res_q : dp_result;
      result_o       = done_ok ? final_res : result_q;
      dbg_state_o    = state_q;
   end

   muldiv_datapath #(.W(DATA_WIDTH)) u_datapath (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (dp_load),
      .iterate  (dp_iterate),
      .op       (op_i),
      .operand1 (operand1_i),
      .operand2 (operand2_i),
      .result   (dp_result)
   );

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed vector bench for muldiv_sequencer: result values, latency, stall
// length, flush and asynchronous reset behaviour.
module tb_muldiv_sequencer;
   import muldiv_sequencer_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        start_i;
   logic        flush_i;
   muldiv_op_e  op_i;
   logic [31:0] operand1_i;
   logic [31:0] operand2_i;
   logic        stall_o;
   logic        busy_o;
   logic        result_valid_o;
   logic [31:0] result_o;
   md_state_e   dbg_state_o;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      muldiv_op_e  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[17];

   muldiv_sequencer dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start_i        (start_i),
      .flush_i        (flush_i),
      .op_i           (op_i),
      .operand1_i     (operand1_i),
      .operand2_i     (operand2_i),
      .stall_o        (stall_o),
      .busy_o         (busy_o),
      .result_valid_o (result_valid_o),
      .result_o       (result_o),
      .dbg_state_o    (dbg_state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Holds start_i high for the whole stall, as the pipeline does.
   task automatic run_op(input vec_t v, input string tag);
      int lat;
      int stalls;
      @(negedge clk);
      start_i    = 1'b1;
      op_i       = v.op;
      operand1_i = v.a;
      operand2_i = v.b;
      #1;
      lat    = 0;
      stalls = 0;
      while (!result_valid_o && lat < 100) begin
         if (stall_o) stalls++;
         @(negedge clk);
         #1;
         lat++;
      end
      check({tag, " latency"}, 32'(lat), 32'(v.lat));
      check({tag, " result"}, result_o, v.exp);
      check({tag, " stall cycles"}, 32'(stalls), 32'(v.lat));
      check({tag, " stall low in done"}, {31'd0, stall_o}, 32'd0);
      start_i = 1'b0;
      @(negedge clk);
      #1;
      check({tag, " valid single pulse"}, {31'd0, result_valid_o}, 32'd0);
      check({tag, " result held"}, result_o, v.exp);
      check({tag, " idle after"}, {31'd0, busy_o}, 32'd0);
   endtask

   task automatic count_valids(input int cycles, output int n);
      n = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         #1;
         if (result_valid_o) n++;
      end
   endtask

   initial begin
      int nv;
      logic [31:0] held;
      vec_t v;

      vecs[0]  = '{MD_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
      vecs[1]  = '{MD_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33};
      vecs[2]  = '{MD_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
      vecs[3]  = '{MD_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
      vecs[4]  = '{MD_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
      vecs[5]  = '{MD_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
      vecs[6]  = '{MD_DIVU,   32'd100,        32'd7,         32'd14,        33};
      vecs[7]  = '{MD_REMU,   32'd100,        32'd7,         32'd2,         33};
      vecs[8]  = '{MD_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1};
      vecs[9]  = '{MD_REMU,   32'd5,          32'd0,         32'd5,         1};
      vecs[10] = '{MD_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
      vecs[11] = '{MD_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
      vecs[12] = '{MD_REM,    32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 1};
      vecs[13] = '{MD_DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         33};
      vecs[14] = '{MD_DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
      vecs[15] = '{MD_REM,    32'd7,          32'hFFFF_FFFE, 32'd1,         33};
      vecs[16] = '{MD_MULH,   32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 33};

      rst_n      = 1'b0;
      start_i    = 1'b0;
      flush_i    = 1'b0;
      op_i       = MD_MUL;
      operand1_i = '0;
      operand2_i = '0;
      repeat (3) @(negedge clk);
      #1;
      check("reset stall", {31'd0, stall_o}, 32'd0);
      check("reset busy", {31'd0, busy_o}, 32'd0);
      check("reset valid", {31'd0, result_valid_o}, 32'd0);
      check("reset result", result_o, 32'd0);
      check("reset state", {30'd0, dbg_state_o}, {30'd0, MD_IDLE});
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 17; i++) run_op(vecs[i], $sformatf("vec%0d", i));

      // Flush at CALC count 10 (cycle T+11).
      held = result_o;
      @(negedge clk);
      start_i    = 1'b1;
      op_i       = MD_MUL;
      operand1_i = 32'd7;
      operand2_i = 32'd3;
      repeat (11) @(negedge clk);
      #1;
      check("flush pre state", {30'd0, dbg_state_o}, {30'd0, MD_CALC});
      flush_i = 1'b1;
      #1;
      check("flush stall low", {31'd0, stall_o}, 32'd0);
      check("flush no valid", {31'd0, result_valid_o}, 32'd0);
      check("flush result kept", result_o, held);
      @(negedge clk);
      flush_i = 1'b0;
      start_i = 1'b0;
      #1;
      check("flush to idle", {30'd0, dbg_state_o}, {30'd0, MD_IDLE});
      check("flush busy low", {31'd0, busy_o}, 32'd0);
      count_valids(40, nv);
      check("flush no later valid", 32'(nv), 32'd0);
      check("flush result still kept", result_o, held);

      // start and flush together in IDLE: nothing accepted.
      @(negedge clk);
      start_i    = 1'b1;
      flush_i    = 1'b1;
      op_i       = MD_DIVU;
      operand1_i = 32'd100;
      operand2_i = 32'd7;
      #1;
      check("start+flush stall", {31'd0, stall_o}, 32'd0);
      @(negedge clk);
      start_i = 1'b0;
      flush_i = 1'b0;
      #1;
      check("start+flush busy", {31'd0, busy_o}, 32'd0);
      count_valids(40, nv);
      check("start+flush no valid", 32'(nv), 32'd0);

      // Asynchronous reset in the middle of CALC.
      @(negedge clk);
      start_i    = 1'b1;
      op_i       = MD_MULHU;
      operand1_i = 32'hFFFF_FFFF;
      operand2_i = 32'hFFFF_FFFF;
      repeat (10) @(negedge clk);
      start_i = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("async rst stall", {31'd0, stall_o}, 32'd0);
      check("async rst busy", {31'd0, busy_o}, 32'd0);
      check("async rst valid", {31'd0, result_valid_o}, 32'd0);
      check("async rst result", result_o, 32'd0);
      check("async rst state", {30'd0, dbg_state_o}, {30'd0, MD_IDLE});
      @(negedge clk);
      rst_n = 1'b1;
      v = '{MD_MULHU, 32'd3, 32'd5, 32'd0, 33};
      run_op(v, "post-reset mulhu");

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
